// File: rtl/hsstl_phy_mac_rxvalid_gen.sv
// RX symbol-lock FSM, 1-cycle registered PIPE word with rxvalid,
// and saturating per-status error counters (pclk domain).
module hsstl_phy_mac_rxvalid_gen #(
    parameter int LOCK_COM_CNT = 4,
    parameter int ALIGN_TMO    = 64,
    parameter int WIN_LEN      = 128,
    parameter int ERR_LIMIT    = 4,
    parameter int CNT_W        = 16
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [31:0]      rxdata_i,
    input  logic [3:0]       rxdatak_i,
    input  logic [2:0]       rxstatus_i,
    input  logic             rx_elec_idle,
    input  logic             clr_cnt,
    output logic [31:0]      phy_mac_rxdata,
    output logic [3:0]       phy_mac_rxdatak,
    output logic [2:0]       phy_mac_rxstatus,
    output logic             phy_mac_rxvalid,
    output logic             sym_lock,
    output logic [CNT_W-1:0] dec_err_cnt,
    output logic [CNT_W-1:0] disp_err_cnt,
    output logic [CNT_W-1:0] ctc_ovf_cnt,
    output logic [CNT_W-1:0] ctc_unf_cnt,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam int CW = $clog2(LOCK_COM_CNT + 1);
    localparam int TW = (ALIGN_TMO > 1) ? $clog2(ALIGN_TMO) : 1;
    localparam int WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int EW = $clog2(ERR_LIMIT + 1);

    localparam logic [CW-1:0] COM_ONE  = CW'(1);
    localparam logic [CW-1:0] LOCK_N   = CW'(LOCK_COM_CNT);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ALIGN_TMO - 1);
    localparam logic [WW-1:0] WIN_ONE  = WW'(1);
    localparam logic [WW-1:0] WIN_LAST = WW'(WIN_LEN - 1);
    localparam logic [EW-1:0] ERR_ONE  = EW'(1);
    localparam logic [EW-1:0] ERR_N    = EW'(ERR_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ALIGN  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_com_cnt;
    logic [TW-1:0]   r_tmo_cnt;
    logic [WW-1:0]   r_win_cnt;
    logic [EW-1:0]   r_err_in_win;

    logic w_com;
    logic w_err;
    logic w_clean_com;
    logic w_lim_hit;
    logic w_lock_loss;
    logic w_valid_nxt;

    assign w_com       = rxdatak_i[0] && (rxdata_i[7:0] == 8'hBC);
    assign w_err       = (rxstatus_i == 3'b100) || (rxstatus_i == 3'b111);
    assign w_clean_com = !rx_elec_idle && w_com && !w_err;
    assign w_lim_hit   = w_err && ((r_err_in_win + ERR_ONE) == ERR_N);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_clean_com)
                    w_next = (LOCK_COM_CNT == 1) ? S_LOCKED : S_ALIGN;
            end
            S_ALIGN: begin
                w_next = S_ALIGN;
                if (rx_elec_idle || w_err)
                    w_next = S_IDLE;
                else if (w_com) begin
                    if ((r_com_cnt + COM_ONE) == LOCK_N)
                        w_next = S_LOCKED;
                end else if (r_tmo_cnt == TMO_LAST)
                    w_next = S_IDLE;
            end
            S_LOCKED: begin
                w_next = S_LOCKED;
                if (rx_elec_idle || w_lim_hit)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_lock_loss = (r_state == S_LOCKED) && (w_next != S_LOCKED);
        w_valid_nxt = (w_next == S_LOCKED);
    end

    // Lock-acquisition and error-window bookkeeping
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_com_cnt    <= '0;
            r_tmo_cnt    <= '0;
            r_win_cnt    <= '0;
            r_err_in_win <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_com_cnt <= w_clean_com ? COM_ONE : '0;
                    r_tmo_cnt <= '0;
                end
                S_ALIGN: begin
                    if (rx_elec_idle || w_err) begin
                        r_com_cnt <= '0;
                    end else if (w_com) begin
                        r_com_cnt <= r_com_cnt + COM_ONE;
                        r_tmo_cnt <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
                    end
                end
                default: begin
                    r_com_cnt <= '0;
                    r_tmo_cnt <= '0;
                end
            endcase
            // The wrap word's error seeds the next window
            if (r_state != S_LOCKED) begin
                r_win_cnt    <= '0;
                r_err_in_win <= '0;
            end else if (r_win_cnt == WIN_LAST) begin
                r_win_cnt    <= '0;
                r_err_in_win <= EW'(w_err);
            end else begin
                r_win_cnt    <= r_win_cnt + WIN_ONE;
                r_err_in_win <= r_err_in_win + EW'(w_err);
            end
        end
    end

    function automatic logic [CNT_W-1:0] f_cnt(
        input logic [CNT_W-1:0] c,
        input logic             inc,
        input logic             clr
    );
        if (clr)                  return '0;
        else if (inc && (c != '1)) return c + CNT_W'(1);
        else                      return c;
    endfunction

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            phy_mac_rxdata   <= '0;
            phy_mac_rxdatak  <= '0;
            phy_mac_rxstatus <= '0;
            phy_mac_rxvalid  <= 1'b0;
            sym_lock         <= 1'b0;
            dec_err_cnt      <= '0;
            disp_err_cnt     <= '0;
            ctc_ovf_cnt      <= '0;
            ctc_unf_cnt      <= '0;
            lock_loss_cnt    <= '0;
        end else begin
            phy_mac_rxdata   <= rxdata_i;
            phy_mac_rxdatak  <= rxdatak_i;
            phy_mac_rxstatus <= rxstatus_i;
            phy_mac_rxvalid  <= w_valid_nxt;
            sym_lock         <= w_valid_nxt;
            dec_err_cnt      <= f_cnt(dec_err_cnt,
                                !rx_elec_idle && (rxstatus_i == 3'b100), clr_cnt);
            disp_err_cnt     <= f_cnt(disp_err_cnt,
                                !rx_elec_idle && (rxstatus_i == 3'b111), clr_cnt);
            ctc_ovf_cnt      <= f_cnt(ctc_ovf_cnt,
                                !rx_elec_idle && (rxstatus_i == 3'b101), clr_cnt);
            ctc_unf_cnt      <= f_cnt(ctc_unf_cnt,
                                !rx_elec_idle && (rxstatus_i == 3'b110), clr_cnt);
            lock_loss_cnt    <= f_cnt(lock_loss_cnt, w_lock_loss, clr_cnt);
        end
    end

endmodule
